// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, byte-lane width
// and baud-timer derivation helpers.
package uart_pkg;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int calc_bit_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half_cnt(input int clk_freq, input int baud);
    return calc_bit_cnt(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_word_if.sv
// Word-side output bundle of the UART word receiver; the receiver drives it
// through the master modport.
interface uart_rx_word_if;
  logic [31:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        word_drop;
  logic        busy;

  modport master (output data, data_valid, frame_err, word_drop, busy);
  modport slave  (input  data, data_valid, frame_err, word_drop, busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: rx synchroniser, start/data/stop FSM, bit timer and
// shift register. byte_done/frame_err strobe combinationally on the stop sample.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_done,
  output logic        frame_err,
  output logic        busy
);

  localparam int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int HALF_CNT = calc_half_cnt(CLK_FREQ, BAUD);
  localparam int TMR_W    = $clog2(BIT_CNT) + 1;

  uart_state_e      state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_s;
  logic             fall_s;

  // sync_q[2] is the edge-detect flop trailing the two synchroniser stages
  assign sync_d = {sync_q[1:0], rx};
  assign rx_s   = sync_q[1];
  assign fall_s = sync_q[2] & ~sync_q[1];

  // state, timer, shift register and synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sync_q    <= 3'b111;
      tmr_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      tmr_q     <= tmr_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // next-state and sample strobes
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // mid-start check rejects glitches shorter than half a bit
        if (tmr_q == TMR_W'(HALF_CNT - 1)) begin
          tmr_d     = '0;
          bit_idx_d = 3'd0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_DATA: begin
        if (tmr_q == TMR_W'(BIT_CNT - 1)) begin
          tmr_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_STOP: begin
        // leave in mid-stop-bit so a zero-gap start edge is still seen
        if (tmr_q == TMR_W'(BIT_CNT - 1)) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            byte_done = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  assign byte_data = shift_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rx_word.sv
// UART word receiver: packs four 8N1 bytes (first byte in [31:24]) into a word.
// Optional partial-word idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx,
  uart_rx_word_if.master  bus
);

  logic [7:0]  byte_s;
  logic        byte_done_s;
  logic        frame_err_s;
  logic        busy_s;

  logic [1:0]  idx_q, idx_d;
  logic [31:0] stage_q, stage_d;
  logic [31:0] data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        word_drop_q, word_drop_d;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (byte_s),
    .byte_done (byte_done_s),
    .frame_err (frame_err_s),
    .busy      (busy_s)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int          BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD);
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BIT_CNT;
  logic [31:0] idle_cnt_q, idle_cnt_d;

  // idle-gap counter for partial-word timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`endif

  // word assembly and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= 2'd0;
      stage_q      <= 32'd0;
      data_q       <= 32'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_drop_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      word_drop_q  <= word_drop_d;
    end
  end

  // lane assembler and optional timeout
  always_comb begin
    idx_d        = idx_q;
    stage_d      = stage_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = frame_err_s;
    word_drop_d  = 1'b0;
    if (frame_err_s) begin
      idx_d = 2'd0;
    end else if (byte_done_s) begin
      case (idx_q)
        2'd0:    stage_d[31:24] = byte_s;
        2'd1:    stage_d[23:16] = byte_s;
        2'd2:    stage_d[15:8]  = byte_s;
        default: stage_d[7:0]   = byte_s;
      endcase
      if (idx_q == 2'd3) begin
        data_d       = {stage_q[31:8], byte_s};
        data_valid_d = 1'b1;
        idx_d        = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else begin
      idx_d = idx_q;
    end
`ifdef UART_RX_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    // any byte activity (including start detection) restarts the gap count
    if (busy_s || (idx_q == 2'd0)) begin
      idle_cnt_d = 32'd0;
    end else if (idle_cnt_q == TO_LIMIT - 32'd1) begin
      idle_cnt_d  = 32'd0;
      idx_d       = 2'd0;
      stage_d     = 32'd0;
      word_drop_d = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
`endif
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.word_drop  = word_drop_q;
  assign bus.busy       = busy_s;

endmodule
